// File: rtl/hwpe_stream_split_buffered.sv
// Splits one wide valid/ready stream into NB_OUT_STREAMS registered narrow lanes.
// Latency: 1 cycle from wide push to lane pop_valid_o (lane registers, no bypass).
// Backpressure: push_ready_o is high only when every lane is empty or popping this cycle.
module hwpe_stream_split_buffered #(
  parameter int unsigned NB_OUT_STREAMS   = 2,
  parameter int unsigned DATA_WIDTH_OUT   = 8,
  parameter bit          DROP_EMPTY_LANES = 1'b0
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        clear_i,
  input  logic                                        push_valid_i,
  output logic                                        push_ready_o,
  input  logic [NB_OUT_STREAMS*DATA_WIDTH_OUT-1:0]    push_data_i,
  input  logic [NB_OUT_STREAMS*DATA_WIDTH_OUT/8-1:0]  push_strb_i,
  output logic [NB_OUT_STREAMS-1:0]                   pop_valid_o,
  input  logic [NB_OUT_STREAMS-1:0]                   pop_ready_i,
  output logic [NB_OUT_STREAMS*DATA_WIDTH_OUT-1:0]    pop_data_o,
  output logic [NB_OUT_STREAMS*DATA_WIDTH_OUT/8-1:0]  pop_strb_o,
  output logic                                        busy_o
);

  localparam int unsigned N  = NB_OUT_STREAMS;
  localparam int unsigned W  = DATA_WIDTH_OUT;
  localparam int unsigned SW = DATA_WIDTH_OUT / 8;

  // Parameter sanity: fewer than two lanes is not a split, and strobes need whole bytes.
  if (NB_OUT_STREAMS < 2) begin : g_bad_nb_out_streams
    $error("hwpe_stream_split_buffered: NB_OUT_STREAMS must be >= 2");
  end
  if ((DATA_WIDTH_OUT % 8) != 0) begin : g_bad_data_width_out
    $error("hwpe_stream_split_buffered: DATA_WIDTH_OUT must be a multiple of 8");
  end

  logic [N-1:0]    lane_full;
  logic [N*W-1:0]  lane_data;
  logic [N*SW-1:0] lane_strb;
  logic [N-1:0]    lane_free;
  logic [N-1:0]    lane_keep;
  logic            push_hs;

  // A lane can take a new slice if it is empty or its consumer drains it this cycle;
  // with lane dropping enabled, an all-zero strobe slice leaves the lane empty.
  always_comb begin
    lane_free = ~lane_full | pop_ready_i;
    lane_keep = '0;
    for (int k = 0; k < N; k++) begin
      lane_keep[k] = (DROP_EMPTY_LANES == 1'b0) || (|push_strb_i[k*SW +: SW]);
    end
  end

  // Ready is withheld during reset/clear so an upstream beat is never lost to the reset.
  assign push_ready_o = (&lane_free) & ~rst_i & ~clear_i;
  assign push_hs      = push_valid_i & push_ready_o;

  assign pop_valid_o = lane_full;
  assign pop_data_o  = lane_data;
  assign pop_strb_o  = lane_strb;
  assign busy_o      = |lane_full;

  // Lane registers: reload on a wide push (even while popping), otherwise clear on pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lane_full <= '0;
      lane_data <= '0;
      lane_strb <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push_hs) begin
          if (lane_keep[k]) begin
            lane_full[k]          <= 1'b1;
            lane_data[k*W +: W]   <= push_data_i[k*W +: W];
            lane_strb[k*SW +: SW] <= push_strb_i[k*SW +: SW];
          end else begin
            lane_full[k]          <= 1'b0;
            lane_data[k*W +: W]   <= '0;
            lane_strb[k*SW +: SW] <= '0;
          end
        end else if (lane_full[k] && pop_ready_i[k]) begin
          lane_full[k] <= 1'b0;
        end
      end
    end
  end

  // A stalled lane must present the same payload until its consumer takes it.
  for (genvar k = 0; k < N; k++) begin : g_pop_stable
    a_pop_stable: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
      (pop_valid_o[k] && !pop_ready_i[k]) |=>
        ($stable(pop_data_o[k*W +: W]) && $stable(pop_strb_o[k*SW +: SW])));
  end

  // An upstream beat left pending must not change its payload while still offered.
  a_push_stable: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    (push_valid_i && !push_ready_o) |=> (!push_valid_i || $stable(push_data_i)));

endmodule
